// File: rtl/hazard_sched_pkg.sv
// Shared types and encodings for the hazard_sched pipeline controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEL_PC4    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    localparam logic [1:0] FWD_SRC   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Register 0 is hard-wired, so it can never produce a hazard or a forward.
    function automatic logic hit(input logic [4:0] r, input logic [4:0] rd, input logic we);
        return we & (rd == r) & (r != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_sched_fwd_sel.sv
// Operand forwarding select for one ALU input; EX/MEM beats MEM/WB, loads in MEM excluded.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] exReg,
    input  logic [4:0] memRd,
    input  logic       memRegwrite,
    input  logic       memMemread,
    input  logic [4:0] wbRd,
    input  logic       wbRegwrite,
    output logic [1:0] sel
);

    // Nearest producer wins.
    always_comb begin
        if (hit(exReg, memRd, memRegwrite) && !memMemread) begin
            sel = FWD_EXMEM;
        end else if (hit(exReg, wbRd, wbRegwrite)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_SRC;
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// Hazard controller for the 5-stage MIPS pipeline: stalls, flushes, PC select, forwarding.
// Define HAZARD_FWD_EN to enable operand forwarding (only load-use then stalls).
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_jump,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       pc_sel,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t     state_r, retState_r, nextState_s, nextRet_s, effState_s;
    logic [1:0] waitCnt_r, nextWait_s, hazardCnt_s;
    logic       memBusy_s, rawEx_s, hazard_s;
    logic       pcWe_s, ifidWe_s, flush_s, bubble_s, freeze_s;
    logic [1:0] pcSel_s, fwdRawA_s, fwdRawB_s;

    assign memBusy_s  = (mem_memread | mem_memwrite) & ~dmem_ready;
    assign effState_s = (state_r == MEM_WAIT) ? retState_r : state_r;
    assign rawEx_s    = (id_use_rs & hit(id_rs, ex_rd, ex_regwrite))
                      | (id_use_rt & hit(id_rt, ex_rd, ex_regwrite));

`ifdef HAZARD_FWD_EN
    assign hazard_s    = ex_memread & rawEx_s;
    assign hazardCnt_s = 2'd1;

    fwd_sel u_fwdA (
        .exReg(ex_rs), .memRd(mem_rd), .memRegwrite(mem_regwrite), .memMemread(mem_memread),
        .wbRd(wb_rd), .wbRegwrite(wb_regwrite), .sel(fwdRawA_s)
    );
    fwd_sel u_fwdB (
        .exReg(ex_rt), .memRd(mem_rd), .memRegwrite(mem_regwrite), .memMemread(mem_memread),
        .wbRd(wb_rd), .wbRegwrite(wb_regwrite), .sel(fwdRawB_s)
    );
`else
    logic rawMem_s;
    logic unusedFwd_s;

    // With a write-first register file a WB producer never needs a stall.
    assign rawMem_s    = (id_use_rs & hit(id_rs, mem_rd, mem_regwrite))
                       | (id_use_rt & hit(id_rt, mem_rd, mem_regwrite));
    assign hazard_s    = rawEx_s | rawMem_s;
    assign hazardCnt_s = rawEx_s ? 2'd2 : 2'd1;
    assign fwdRawA_s   = FWD_SRC;
    assign fwdRawB_s   = FWD_SRC;
    assign unusedFwd_s = ^{ex_rs, ex_rt, ex_memread, wb_rd, wb_regwrite};
`endif

    // Priority decode of pipeline controls and next FSM state; the hazard cycle is the first stall cycle.
    always_comb begin
        pcWe_s      = 1'b1;
        ifidWe_s    = 1'b1;
        flush_s     = 1'b0;
        bubble_s    = 1'b0;
        freeze_s    = 1'b0;
        pcSel_s     = PC_SEL_PC4;
        nextState_s = RUN;
        nextWait_s  = waitCnt_r;
        nextRet_s   = retState_r;
        if (memBusy_s) begin
            pcWe_s      = 1'b0;
            ifidWe_s    = 1'b0;
            freeze_s    = 1'b1;
            nextState_s = MEM_WAIT;
            if (state_r != MEM_WAIT) begin
                nextRet_s = state_r;
            end else begin
                nextRet_s = retState_r;
            end
        end else if (ex_branch_taken) begin
            pcSel_s    = PC_SEL_BRANCH;
            flush_s    = 1'b1;
            bubble_s   = 1'b1;
            nextWait_s = 2'd0;
        end else if (effState_s == STALL) begin
            pcWe_s   = 1'b0;
            ifidWe_s = 1'b0;
            bubble_s = 1'b1;
            if (waitCnt_r > 2'd1) begin
                nextWait_s  = waitCnt_r - 2'd1;
                nextState_s = STALL;
            end else begin
                nextWait_s  = 2'd0;
                nextState_s = RUN;
            end
        end else if (hazard_s) begin
            pcWe_s     = 1'b0;
            ifidWe_s   = 1'b0;
            bubble_s   = 1'b1;
            nextWait_s = hazardCnt_s - 2'd1;
            if (hazardCnt_s > 2'd1) begin
                nextState_s = STALL;
            end else begin
                nextState_s = RUN;
            end
        end else if (id_jump) begin
            pcSel_s = PC_SEL_JUMP;
            flush_s = 1'b1;
        end else begin
            nextState_s = RUN;
        end
    end

    // Reset overrides the decode immediately, independent of the clock.
    always_comb begin
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_freeze = 1'b0;
            pc_sel      = PC_SEL_PC4;
            fwd_a       = FWD_SRC;
            fwd_b       = FWD_SRC;
        end else begin
            pc_we       = pcWe_s;
            ifid_we     = ifidWe_s;
            ifid_flush  = flush_s;
            idex_bubble = bubble_s;
            pipe_freeze = freeze_s;
            pc_sel      = pcSel_s;
            fwd_a       = memBusy_s ? FWD_SRC : fwdRawA_s;
            fwd_b       = memBusy_s ? FWD_SRC : fwdRawB_s;
        end
    end

    // FSM state, stall countdown and the state to resume after a memory wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN;
            waitCnt_r  <= 2'd0;
            retState_r <= RUN;
        end else begin
            state_r    <= nextState_s;
            waitCnt_r  <= nextWait_s;
            retState_r <= nextRet_s;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= {CNT_W{1'b0}};
        end else if (!pcWe_s && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed self-checking bench for hazard_sched; expectations follow HAZARD_FWD_EN.
module tb_hazard_sched;
    import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze, pc_sel, fwd_a, fwd_b}
    localparam logic [10:0] V_NORMAL = 11'b11000_00_00_00;
    localparam logic [10:0] V_RESET  = 11'b00110_00_00_00;
    localparam logic [10:0] V_STALL  = 11'b00010_00_00_00;
    localparam logic [10:0] V_FREEZE = 11'b00001_00_00_00;
    localparam logic [10:0] V_BRANCH = 11'b11110_01_00_00;
    localparam logic [10:0] V_JUMP   = 11'b11100_10_00_00;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_use_rs, id_use_rt, id_jump, ex_regwrite, ex_memread, ex_branch_taken;
    logic mem_regwrite, mem_memread, mem_memwrite, wb_regwrite, dmem_ready;
    logic pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze;
    logic [1:0] pc_sel, fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic [10:0] ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze, pc_sel, fwd_a, fwd_b};

    always #5 clk = ~clk;

    hazard_sched #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_jump(id_jump),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .pipe_freeze(pipe_freeze), .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_jump = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        ex_branch_taken = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; mem_memread = 1'b0; mem_memwrite = 1'b0;
        wb_rd = 5'd0; wb_regwrite = 1'b0; dmem_ready = 1'b1;
    endtask

    // Inputs change 2 time units after a rising edge and are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (ctl !== V_RESET) begin errors++; $display("FAIL reset_outputs: got %b expected %b", ctl, V_RESET); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
        next_cycle();
        rst_n = 1'b1;
        #1;
        checks++; if (ctl !== V_NORMAL) begin errors++; $display("FAIL reset_release: got %b expected %b", ctl, V_NORMAL); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1'b1; ex_rd = 5'd2; ex_regwrite = 1'b1; id_rs = 5'd2; id_use_rs = 1'b1;
        #1;
        checks++; if (ctl !== V_STALL) begin errors++; $display("FAIL lu_detect: got %b expected %b", ctl, V_STALL); end
        next_cycle();
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
        mem_rd = 5'd2; mem_regwrite = 1'b1; mem_memread = 1'b1;
        #1;
        checks++; if (ctl !== (FWD ? V_NORMAL : V_STALL)) begin
            errors++; $display("FAIL lu_second: got %b expected %b", ctl, FWD ? V_NORMAL : V_STALL);
        end
        next_cycle();
        mem_rd = 5'd0; mem_regwrite = 1'b0; mem_memread = 1'b0; wb_rd = 5'd2; wb_regwrite = 1'b1;
        #1;
        checks++; if (ctl !== V_NORMAL) begin errors++; $display("FAIL lu_resume: got %b expected %b", ctl, V_NORMAL); end
        checks++; if (stall_cnt !== (FWD ? 16'd1 : 16'd2)) begin
            errors++; $display("FAIL lu_cnt: got %0d expected %0d", stall_cnt, FWD ? 1 : 2);
        end
    endtask

    task automatic test_forward();
        do_reset();
        ex_rs = 5'd3; mem_rd = 5'd3; mem_regwrite = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1;
        #1;
        checks++; if (fwd_a !== (FWD ? FWD_EXMEM : FWD_SRC)) begin errors++; $display("FAIL fwd_exmem: got %b", fwd_a); end
        mem_regwrite = 1'b0;
        #1;
        checks++; if (fwd_a !== (FWD ? FWD_MEMWB : FWD_SRC)) begin errors++; $display("FAIL fwd_memwb: got %b", fwd_a); end
        ex_rs = 5'd0;
        #1;
        checks++; if (fwd_a !== FWD_SRC) begin errors++; $display("FAIL fwd_r0: got %b expected 00", fwd_a); end
        ex_rt = 5'd4; mem_rd = 5'd4; mem_regwrite = 1'b1; mem_memread = 1'b1; wb_rd = 5'd4;
        #1;
        checks++; if (fwd_b !== (FWD ? FWD_MEMWB : FWD_SRC)) begin errors++; $display("FAIL fwd_b_load: got %b", fwd_b); end
        checks++; if (fwd_a !== FWD_SRC) begin errors++; $display("FAIL fwd_a_idle: got %b expected 00", fwd_a); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_memread = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== V_FREEZE) begin errors++; $display("FAIL mw_freeze%0d: got %b expected %b", i, ctl, V_FREEZE); end
            next_cycle();
        end
        dmem_ready = 1'b1;
        #1;
        checks++; if (ctl !== V_NORMAL) begin errors++; $display("FAIL mw_release: got %b expected %b", ctl, V_NORMAL); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL mw_cnt: got %0d expected 3", stall_cnt); end
    endtask

    task automatic test_busy_hazard();
        do_reset();
        mem_memwrite = 1'b1; dmem_ready = 1'b0;
        ex_memread = 1'b1; ex_rd = 5'd2; ex_regwrite = 1'b1; id_rs = 5'd2; id_use_rs = 1'b1;
        #1;
        checks++; if (ctl !== V_FREEZE) begin errors++; $display("FAIL bh_freeze: got %b expected %b", ctl, V_FREEZE); end
        next_cycle();
        dmem_ready = 1'b1;
        #1;
        checks++; if (ctl !== V_STALL) begin errors++; $display("FAIL bh_redetect: got %b expected %b", ctl, V_STALL); end
    endtask

    task automatic test_branch_jump();
        do_reset();
        ex_branch_taken = 1'b1; id_jump = 1'b1;
        #1;
        checks++; if (ctl !== V_BRANCH) begin errors++; $display("FAIL br_over_jump: got %b expected %b", ctl, V_BRANCH); end
        next_cycle();
        ex_branch_taken = 1'b0;
        #1;
        checks++; if (ctl !== V_JUMP) begin errors++; $display("FAIL jump: got %b expected %b", ctl, V_JUMP); end
        next_cycle();
        id_jump = 1'b0; ex_branch_taken = 1'b1;
        ex_memread = 1'b1; ex_rd = 5'd6; ex_regwrite = 1'b1; id_rt = 5'd6; id_use_rt = 1'b1;
        #1;
        checks++; if (ctl !== V_BRANCH) begin errors++; $display("FAIL br_over_hazard: got %b expected %b", ctl, V_BRANCH); end
        next_cycle();
        idle();
        #1;
        checks++; if (ctl !== V_NORMAL) begin errors++; $display("FAIL br_no_stall: got %b expected %b", ctl, V_NORMAL); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL br_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_raw_nofwd();
        do_reset();
        id_rs = 5'd5; id_use_rs = 1'b1; ex_rd = 5'd5; ex_regwrite = 1'b1;
        #1;
        checks++; if (ctl !== (FWD ? V_NORMAL : V_STALL)) begin errors++; $display("FAIL raw_ex1: got %b", ctl); end
        next_cycle();
        ex_regwrite = 1'b0; ex_rd = 5'd0; mem_rd = 5'd5; mem_regwrite = 1'b1;
        #1;
        checks++; if (ctl !== (FWD ? V_NORMAL : V_STALL)) begin errors++; $display("FAIL raw_ex2: got %b", ctl); end
        next_cycle();
        mem_regwrite = 1'b0; mem_rd = 5'd0; wb_rd = 5'd5; wb_regwrite = 1'b1; ex_rs = 5'd5;
        #1;
        checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL raw_wb_nostall: got %b expected 1", pc_we); end
        checks++; if (fwd_a !== (FWD ? FWD_MEMWB : FWD_SRC)) begin errors++; $display("FAIL raw_fwd_a: got %b", fwd_a); end
        checks++; if (stall_cnt !== (FWD ? 16'd0 : 16'd2)) begin errors++; $display("FAIL raw_cnt: got %0d", stall_cnt); end
        next_cycle();
        idle();
        id_rt = 5'd7; id_use_rt = 1'b1; mem_rd = 5'd7; mem_regwrite = 1'b1;
        #1;
        checks++; if (ctl !== (FWD ? V_NORMAL : V_STALL)) begin errors++; $display("FAIL raw_mem1: got %b", ctl); end
        next_cycle();
        mem_regwrite = 1'b0;
        #1;
        checks++; if (ctl !== V_NORMAL) begin errors++; $display("FAIL raw_mem_done: got %b expected %b", ctl, V_NORMAL); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        ex_memread = 1'b1; ex_rd = 5'd5; ex_regwrite = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
        #1;
        checks++; if (ctl !== V_STALL) begin errors++; $display("FAIL rs_stall1: got %b expected %b", ctl, V_STALL); end
        next_cycle();
        #1;
        checks++; if (ctl !== V_STALL) begin errors++; $display("FAIL rs_stall2: got %b expected %b", ctl, V_STALL); end
        rst_n = 1'b0;
        #1;
        checks++; if (ctl !== V_RESET) begin errors++; $display("FAIL rs_async: got %b expected %b", ctl, V_RESET); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rs_cnt_clear: got %0d expected 0", stall_cnt); end
        next_cycle();
        idle();
        rst_n = 1'b1;
        next_cycle();
        #1;
        checks++; if (ctl !== V_NORMAL) begin errors++; $display("FAIL rs_resume: got %b expected %b", ctl, V_NORMAL); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rs_cnt_after: got %0d expected 0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_busy_hazard();
        test_branch_jump();
        test_raw_nofwd();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
